// File: rtl/wb_op_sequencer_pkg.sv
// wb_op_sequencer_pkg: shared cache-op/TLB-op encodings and sequencer state type
package wb_op_sequencer_pkg;
   localparam int TLBOP_TLBWI = 0;
   localparam int TLBOP_TLBP  = 1;
   localparam int TLBOP_TLBR  = 2;
   typedef enum logic [2:0] {
      EMPTY,
      I_INDEX_INV,
      I_HIT_INV,
      D_INDEX_WB_INV,
      D_HIT_INV,
      D_HIT_WB_INV,
      D_INDEX_STORE_TAG
   } cache_op_t;
   typedef enum logic [1:0] {IDLE, TLB, CACHE, REDIRECT} wb_seq_state_t;
endpackage

// File: rtl/wb_op_sequencer_if.sv
// wb_op_sequencer_if: writeback/TLB/cache/fetch signals of the op sequencer; timeout_err only with WB_OP_TIMEOUT_EN
interface wb_op_sequencer_if;
   import wb_op_sequencer_pkg::*;
   logic        op_valid;
   logic [2:0]  op_tlb;
   cache_op_t   op_cache;
   logic [31:0] op_pc;
   logic [31:0] op_vaddr;
   logic [31:0] op_paddr;
   logic        flush_in;
   logic [2:0]  tlb_cmd;
   logic        cache_req;
   cache_op_t   cache_op_out;
   logic [31:0] cache_vaddr;
   logic [31:0] cache_paddr;
   logic        cache_ack;
   logic        busy;
   logic        fetch_hold;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
`ifdef WB_OP_TIMEOUT_EN
   logic        timeout_err;
`endif
   modport master (
`ifdef WB_OP_TIMEOUT_EN
      input timeout_err,
`endif
      output op_valid, op_tlb, op_cache, op_pc, op_vaddr, op_paddr, flush_in, cache_ack,
      input tlb_cmd, cache_req, cache_op_out, cache_vaddr, cache_paddr, busy, fetch_hold,
            redirect_valid, redirect_pc
   );
   modport slave (
`ifdef WB_OP_TIMEOUT_EN
      output timeout_err,
`endif
      input op_valid, op_tlb, op_cache, op_pc, op_vaddr, op_paddr, flush_in, cache_ack,
      output tlb_cmd, cache_req, cache_op_out, cache_vaddr, cache_paddr, busy, fetch_hold,
             redirect_valid, redirect_pc
   );
endinterface

// File: rtl/wb_op_sequencer_op_timeout_counter.sv
// op_timeout_counter: cache-ack watchdog counter, expired when the count reaches TIMEOUT_CYCLES-1
module op_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT_CYCLES);
   logic [W-1:0] count;
   // count wait cycles; the sequencer leaves CACHE on expiry so the count never wraps
   always_ff @(posedge clk or posedge reset)
      if (reset) count <= '0;
      else count <= clear ? '0 : en ? count + W'(1) : count;
   assign expired = count == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/wb_op_sequencer.sv
// wb_op_sequencer: issues retired TLB then cache maintenance ops, holds fetch, then one refetch redirect.
// Optional cache-ack watchdog is compiled in by defining WB_OP_TIMEOUT_EN.
module wb_op_sequencer
   import wb_op_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
) (
   input logic clk,
   input logic reset,
   wb_op_sequencer_if.slave bus
);
   wb_seq_state_t state, state_nxt;
   logic [2:0]  tlb_q;
   cache_op_t   cache_q;
   logic [31:0] pc_q, vaddr_q, paddr_q;
   logic        accept, expired;
   assign accept = state == IDLE && bus.op_valid && !bus.flush_in;
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end
`ifdef WB_OP_TIMEOUT_EN
   op_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk(clk),
      .reset(reset),
      .clear(state != CACHE),
      .en(state == CACHE && !bus.cache_ack),
      .expired(expired)
   );
`else
   assign expired = 1'b0;
`endif
   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nxt;
   // capture the op fields when an op is accepted in IDLE
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         tlb_q   <= '0;
         cache_q <= EMPTY;
         pc_q    <= '0;
         vaddr_q <= '0;
         paddr_q <= '0;
      end else if (accept) begin
         tlb_q   <= bus.op_tlb;
         cache_q <= bus.op_cache;
         pc_q    <= bus.op_pc;
         vaddr_q <= bus.op_vaddr;
         paddr_q <= bus.op_paddr;
      end
   // next state: TLB always before cache, ack beats watchdog expiry
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = !accept ? IDLE : bus.op_tlb != 3'b0 ? TLB : bus.op_cache != EMPTY ? CACHE : IDLE;
         TLB:     state_nxt = cache_q != EMPTY ? CACHE : REDIRECT;
         CACHE:   state_nxt = bus.cache_ack || expired ? REDIRECT : CACHE;
         default: state_nxt = IDLE;
      endcase
   end
   // outputs decoded from the state and the latched op
   always_comb begin
      bus.busy           = state != IDLE;
      bus.fetch_hold     = state != IDLE || accept;
      bus.tlb_cmd        = state == TLB ? tlb_q : 3'b0;
      bus.cache_req      = state == CACHE;
      bus.cache_op_out   = cache_q;
      bus.cache_vaddr    = vaddr_q;
      bus.cache_paddr    = paddr_q;
      bus.redirect_valid = state == REDIRECT;
      bus.redirect_pc    = state == REDIRECT ? pc_q + 32'd4 : 32'd0;
`ifdef WB_OP_TIMEOUT_EN
      bus.timeout_err    = state == CACHE && expired && !bus.cache_ack;
`endif
   end
endmodule

// File: tb/tb_wb_op_sequencer.sv
// tb_wb_op_sequencer: scoreboard bench for wb_op_sequencer; expected events queued at stimulus, popped at output
module tb_wb_op_sequencer;
   import wb_op_sequencer_pkg::*;
`ifdef WB_OP_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 256;
`endif
   localparam logic [2:0] T_WI = 3'b001 << TLBOP_TLBWI;
   localparam logic [2:0] T_P  = 3'b001 << TLBOP_TLBP;
   localparam logic [2:0] T_R  = 3'b001 << TLBOP_TLBR;

   typedef struct { int cyc; logic [31:0] val; } ev_t;
   typedef struct { int start; int len; cache_op_t op; logic [31:0] va; logic [31:0] pa; } creq_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   wb_op_sequencer_if bus();
   wb_op_sequencer #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

   ev_t   tq[$];
   ev_t   rq[$];
   creq_t cq[$];
   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;
   int bf = -1;
   int bu = -2;
   int to_cyc = -1;
   bit mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
   endtask

   always @(posedge clk) if (!reset) begin
      assert (!(bus.op_valid && bus.busy)) else $error("op_valid while busy");
      assert ($onehot0(bus.op_tlb)) else $error("op_tlb has more than one bit set");
   end

   // monitor: sampled mid low phase, after the bench has driven inputs for the cycle
   always @(negedge clk) begin
      ev_t e;
      logic er;
      #2;
      if (mon_en) begin
         if (bus.tlb_cmd != 3'b0 || (tq.size() > 0 && tq[0].cyc == cyc)) begin
            if (tq.size() == 0) check("tlb_extra", 32'(bus.tlb_cmd), 32'd0);
            else begin
               e = tq.pop_front();
               check("tlb_cmd", 32'(bus.tlb_cmd), e.val);
               check("tlb_cycle", cyc, e.cyc);
            end
         end
         er = cq.size() > 0 && cyc >= cq[0].start && cyc < cq[0].start + cq[0].len;
         if (bus.cache_req || er) begin
            check("cache_req", 32'(bus.cache_req), 32'(er));
            if (cq.size() > 0) begin
               check("cache_vaddr", bus.cache_vaddr, cq[0].va);
               check("cache_paddr", bus.cache_paddr, cq[0].pa);
               check("cache_op", 32'(bus.cache_op_out), 32'(cq[0].op));
            end
            if (er && cyc == cq[0].start + cq[0].len - 1) void'(cq.pop_front());
         end
         if (bus.redirect_valid || (rq.size() > 0 && rq[0].cyc == cyc)) begin
            if (rq.size() == 0) check("redirect_extra", 32'(bus.redirect_valid), 32'd0);
            else begin
               e = rq.pop_front();
               check("redirect_valid", 32'(bus.redirect_valid), 32'd1);
               check("redirect_cycle", cyc, e.cyc);
               check("redirect_pc", bus.redirect_pc, e.val);
            end
         end
         check("busy", 32'(bus.busy), 32'(cyc >= bf && cyc <= bu));
`ifdef WB_OP_TIMEOUT_EN
         if (bus.timeout_err || cyc == to_cyc) check("timeout_err", 32'(bus.timeout_err), 32'(cyc == to_cyc));
`endif
      end
   end

   // drive one retiring op; ack_d < 0 means never acknowledge the cache request
   task automatic run_op(input logic [2:0] t, input cache_op_t c, input logic [31:0] pc,
                         input logic [31:0] va, input logic [31:0] pa, input int ack_d, input bit fl);
      int n, cs, len;
      bit has_c;
      @(negedge clk);
      to_cyc = -1;
      bus.op_valid = 1'b1;
      bus.op_tlb = t;
      bus.op_cache = c;
      bus.op_pc = pc;
      bus.op_vaddr = va;
      bus.op_paddr = pa;
      bus.flush_in = fl;
      n = cyc;
      has_c = c != EMPTY;
      cs = t != 3'b0 ? n + 2 : n + 1;
      if (!fl && (t != 3'b0 || has_c)) begin
         if (t != 3'b0) tq.push_back('{n + 1, 32'(t)});
         if (has_c) begin
            len = ack_d < 0 ? TO : ack_d + 1;
            cq.push_back('{cs, len, c, va, pa});
            if (ack_d < 0) to_cyc = cs + TO - 1;
            rq.push_back('{cs + len, pc + 32'd4});
            bu = cs + len;
         end else begin
            rq.push_back('{n + 2, pc + 32'd4});
            bu = n + 2;
         end
         bf = n + 1;
      end
      #1 check("fetch_hold", 32'(bus.fetch_hold), 32'(!fl));
      @(negedge clk);
      bus.op_valid = 1'b0;
      bus.flush_in = 1'b0;
      bus.op_tlb = 3'b0;
      bus.op_cache = EMPTY;
      if (has_c && !fl && (t != 3'b0 || has_c) && ack_d >= 0) begin
         while (cyc < cs + ack_d) @(negedge clk);
         bus.cache_ack = 1'b1;
         @(negedge clk);
         bus.cache_ack = 1'b0;
      end
      while (cyc <= bu) @(negedge clk);
   endtask

   initial begin
      bus.op_valid = 1'b0;
      bus.op_tlb = 3'b0;
      bus.op_cache = EMPTY;
      bus.op_pc = '0;
      bus.op_vaddr = '0;
      bus.op_paddr = '0;
      bus.flush_in = 1'b0;
      bus.cache_ack = 1'b0;
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_tlb_cmd", 32'(bus.tlb_cmd), 32'd0);
      check("rst_cache_req", 32'(bus.cache_req), 32'd0);
      check("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
      check("rst_redirect_pc", bus.redirect_pc, 32'd0);
      check("rst_cache_op", 32'(bus.cache_op_out), 32'(EMPTY));
      check("rst_vaddr", bus.cache_vaddr, 32'd0);
      check("rst_paddr", bus.cache_paddr, 32'd0);
      check("rst_fetch_hold", 32'(bus.fetch_hold), 32'd0);
`ifdef WB_OP_TIMEOUT_EN
      check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
`endif
      repeat (2) @(negedge clk);
      reset = 1'b0;
      mon_en = 1'b1;

      run_op(T_WI, EMPTY, 32'h8000_1000, 32'h0, 32'h0, 0, 1'b0);
      run_op(3'b0, D_HIT_INV, 32'h8000_2000, 32'h9fc0_0040, 32'h1fc0_0040, 5, 1'b0);
      run_op(T_P, I_INDEX_INV, 32'h8000_3000, 32'h8000_0100, 32'h0000_0100, 2, 1'b0);
      run_op(T_R, D_INDEX_WB_INV, 32'h8000_4000, 32'h8000_0200, 32'h0000_0200, 0, 1'b1);
      @(negedge clk);
      check("flush_busy", 32'(bus.busy), 32'd0);
      run_op(T_R, EMPTY, 32'hffff_fffc, 32'h0, 32'h0, 0, 1'b0);
      run_op(3'b0, I_HIT_INV, 32'h8000_5000, 32'h8000_0300, 32'h0000_0300, 0, 1'b0);
      run_op(3'b0, EMPTY, 32'h8000_6000, 32'h1234_5678, 32'h8765_4321, 0, 1'b0);
      @(negedge clk);
      bus.cache_ack = 1'b1;
      @(negedge clk);
      bus.cache_ack = 1'b0;
      repeat (2) @(negedge clk);
      run_op(T_WI, D_HIT_WB_INV, 32'h8000_7000, 32'h8000_0400, 32'h0000_0400, 1, 1'b0);
`ifdef WB_OP_TIMEOUT_EN
      run_op(3'b0, D_HIT_WB_INV, 32'h8000_8000, 32'h8000_0500, 32'h0000_0500, -1, 1'b0);
      run_op(3'b0, D_HIT_INV, 32'h8000_9000, 32'h8000_0600, 32'h0000_0600, TO - 1, 1'b0);
`endif

      // async reset in the middle of a cache wait
      mon_en = 1'b0;
      @(negedge clk);
      bus.op_valid = 1'b1;
      bus.op_cache = D_HIT_INV;
      bus.op_pc = 32'h8000_a000;
      bus.op_vaddr = 32'h9fc0_0080;
      bus.op_paddr = 32'h1fc0_0080;
      @(negedge clk);
      bus.op_valid = 1'b0;
      bus.op_cache = EMPTY;
      repeat (3) @(negedge clk);
      check("mid_cache_req", 32'(bus.cache_req), 32'd1);
      check("mid_vaddr", bus.cache_vaddr, 32'h9fc0_0080);
      #2 reset = 1'b1;
      #1;
      check("arst_cache_req", 32'(bus.cache_req), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_vaddr", bus.cache_vaddr, 32'd0);
      check("arst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      to_cyc = -1;
      mon_en = 1'b1;
      repeat (TO + 4) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
